// File: rtl/proc_porf_pkg.sv
// Shared definitions for the processor power-on reset / clock-enable sequencer.
// State encodings and default timing constants used by proc and its benches.
package proc_porf_pkg;

  typedef enum logic [1:0] {
    PORF_RESET   = 2'd0,
    PORF_STRETCH = 2'd1,
    PORF_RUN     = 2'd2,
    PORF_HALT    = 2'd3
  } porf_state_e;

  localparam int unsigned PORF_DIV          = 10;
  localparam int unsigned PORF_RESET_CYCLES = 6;
  localparam int unsigned PORF_SYNC_STAGES  = 2;

endpackage

// File: rtl/proc_porf_if.sv
// Debug/control bundle between the sequencer and its controller.
// master drives halt/step requests, slave is the sequencer.
interface proc_porf_if;

  logic        halt_req;
  logic        step;
  logic        proc_ce;
  logic        proc_resetn;
  logic        halted;
  logic [31:0] proc_cycle;

  modport master (
    output halt_req,
    output step,
    input  proc_ce,
    input  proc_resetn,
    input  halted,
    input  proc_cycle
  );

  modport slave (
    input  halt_req,
    input  step,
    output proc_ce,
    output proc_resetn,
    output halted,
    output proc_cycle
  );

endinterface

// File: rtl/proc_porf_reset_sync.sv
// Reset synchroniser: asynchronous assert, synchronous deassert.
// Output falls SYNC_STAGES clock edges after the reset input falls.
module proc_porf_reset_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic rst_o
);

  if (SYNC_STAGES < 2) begin : g_stages_chk
    $error("SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= sync_d;
  end

  assign rst_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/proc_porf.sv
// Processor clock-enable and stretched reset sequencer with debug halt/step.
// Issues one proc_ce every DIV cycles and counts processor cycles.
module proc_porf
  import proc_porf_pkg::*;
#(
  parameter int unsigned DIV          = PORF_DIV,
  parameter int unsigned RESET_CYCLES = PORF_RESET_CYCLES,
  parameter int unsigned SYNC_STAGES  = PORF_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          reset,
  proc_porf_if.slave    bus
);

  if (DIV < 2) begin : g_div_chk
    $error("DIV must be >= 2");
  end

  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned SC_W  = $clog2(RESET_CYCLES + 2);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(RESET_CYCLES);

  logic rst_i;

  proc_porf_reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk   (clk),
    .reset (reset),
    .rst_o (rst_i)
  );

  porf_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, div_inc;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic             ce_q, ce_d;
  logic             resetn_q, resetn_d;
  logic             halted_q, halted_d;
  logic [31:0]      cyc_q, cyc_d;
  logic             step_q, step_d;
  logic             wrap, step_rise;

  always_comb begin
    wrap      = (div_q == DIV_LAST);
    div_inc   = wrap ? '0 : div_q + 1'b1;
    step_rise = bus.step & ~step_q;
    state_d   = state_q;
    div_d     = div_q;
    sc_d      = sc_q;
    ce_d      = 1'b0;
    resetn_d  = resetn_q;
    halted_d  = halted_q;
    cyc_d     = cyc_q;
    step_d    = bus.step;
    unique case (state_q)
      PORF_RESET: begin
        div_d   = div_inc;
        state_d = PORF_STRETCH;
      end
      PORF_STRETCH: begin
        div_d = div_inc;
        if (wrap) begin
          ce_d = 1'b1;
          sc_d = sc_q + 1'b1;
        end
        // leave on the edge that ends the last stretch pulse
        if (ce_q && sc_q == SC_LAST) begin
          state_d  = PORF_RUN;
          resetn_d = 1'b1;
        end
      end
      PORF_RUN: begin
        if (wrap && bus.halt_req) begin
          state_d  = PORF_HALT;
          halted_d = 1'b1;
          div_d    = '0;
        end else begin
          div_d = div_inc;
          if (wrap) begin
            ce_d  = 1'b1;
            cyc_d = cyc_q + 1'b1;
          end
        end
      end
      PORF_HALT: begin
        div_d = '0;
        // release takes priority over a coincident step edge
        if (!bus.halt_req) begin
          state_d  = PORF_RUN;
          halted_d = 1'b0;
        end else if (step_rise) begin
          ce_d  = 1'b1;
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = PORF_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= PORF_RESET;
      div_q    <= '0;
      sc_q     <= '0;
      ce_q     <= 1'b0;
      resetn_q <= 1'b0;
      halted_q <= 1'b0;
      cyc_q    <= '0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sc_q     <= sc_d;
      ce_q     <= ce_d;
      resetn_q <= resetn_d;
      halted_q <= halted_d;
      cyc_q    <= cyc_d;
      step_q   <= step_d;
    end
  end

  assign bus.proc_ce     = ce_q;
  assign bus.proc_resetn = resetn_q;
  assign bus.halted      = halted_q;
  assign bus.proc_cycle  = cyc_q;

endmodule

// File: tb/tb_proc_porf.sv
// Directed bench for proc_porf with a pulse scoreboard.
// Expected proc_ce pulses are queued at stimulus time and popped on arrival.
module tb_proc_porf;
  import proc_porf_pkg::*;

  typedef struct {
    int          t;
    logic [31:0] pc;
    logic        rn;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   npulse = 0;
  int   r0;
  int   n;
  exp_t expq[$];

  proc_porf_if bus();

  proc_porf #(
    .DIV(PORF_DIV),
    .RESET_CYCLES(PORF_RESET_CYCLES),
    .SYNC_STAGES(PORF_SYNC_STAGES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int t, input logic [31:0] pc, input logic rn);
    exp_t e;
    e.t  = t;
    e.pc = pc;
    e.rn = rn;
    expq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus.proc_ce === 1'b1) begin
      npulse++;
      if (expq.size() == 0) begin
        chk("unexpected_ce", {31'd0, bus.proc_ce}, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("ce_time", cyc, e.t);
        chk("ce_cycle", bus.proc_cycle, e.pc);
        chk("ce_resetn", {31'd0, bus.proc_resetn}, {31'd0, e.rn});
      end
    end
  end

  initial begin
    bus.halt_req = 1'b0;
    bus.step     = 1'b0;
    wait_to(3);
    chk("rst_ce", {31'd0, bus.proc_ce}, 32'd0);
    chk("rst_resetn", {31'd0, bus.proc_resetn}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_cycle", bus.proc_cycle, 32'd0);

    // release: 6 stretch pulses then 100 run pulses
    reset = 1'b0;
    r0 = cyc;
    for (int k = 1; k <= 106; k++)
      push(r0 + 2 + 10 * k, (k > 6) ? 32'(k - 6) : 32'd0, k > 6);
    wait_to(r0 + 65);
    chk("resetn_after_stretch", {31'd0, bus.proc_resetn}, 32'd1);
    wait_to(r0 + 1065);
    chk("run_cycle_100", bus.proc_cycle, 32'd100);
    chk("run_pulses", npulse, 106);
    chk("run_queue", expq.size(), 0);

    // halt mid processor cycle
    bus.halt_req = 1'b1;
    wait_to(r0 + 1071);
    chk("halted_before_wrap", {31'd0, bus.halted}, 32'd0);
    wait_to(r0 + 1072);
    chk("halted_at_wrap", {31'd0, bus.halted}, 32'd1);
    wait_to(r0 + 1085);
    chk("halt_cycle_frozen", bus.proc_cycle, 32'd100);
    chk("halt_pulses", npulse, 106);

    // three single steps, the last one held high
    for (int i = 0; i < 3; i++) begin
      bus.step = 1'b1;
      push(cyc + 1, 32'(101 + i), 1'b1);
      wait_to(cyc + ((i == 2) ? 12 : 3));
      bus.step = 1'b0;
      wait_to(cyc + 3);
    end
    chk("step_cycle", bus.proc_cycle, 32'd103);
    chk("step_halted", {31'd0, bus.halted}, 32'd1);
    chk("step_pulses", npulse, 109);

    // release coincident with a step edge
    n = cyc;
    bus.step     = 1'b1;
    bus.halt_req = 1'b0;
    push(n + 11, 32'd104, 1'b1);
    wait_to(n + 1);
    chk("release_halted", {31'd0, bus.halted}, 32'd0);
    wait_to(n + 12);
    bus.step     = 1'b0;
    bus.halt_req = 1'b1;
    wait_to(n + 22);
    chk("rehalt_halted", {31'd0, bus.halted}, 32'd1);
    chk("rehalt_cycle", bus.proc_cycle, 32'd104);

    // counter wrap in RUN
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    #1;
    chk("preload", bus.proc_cycle, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    n = cyc;
    bus.halt_req = 1'b0;
    push(n + 11, 32'd0, 1'b1);
    wait_to(n + 12);
    bus.halt_req = 1'b1;
    wait_to(n + 22);
    chk("wrap_cycle", bus.proc_cycle, 32'd0);
    chk("wrap_halted", {31'd0, bus.halted}, 32'd1);

    // asynchronous reset while halted with a full counter
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    @(posedge clk);
    #3;
    chk("preload_halt", bus.proc_cycle, 32'hFFFF_FFFF);
    reset = 1'b1;
    #1;
    chk("async_cycle", bus.proc_cycle, 32'd0);
    chk("async_halted", {31'd0, bus.halted}, 32'd0);
    chk("async_resetn", {31'd0, bus.proc_resetn}, 32'd0);
    chk("async_ce", {31'd0, bus.proc_ce}, 32'd0);

    wait_to(cyc + 5);
    chk("queue_drained", expq.size(), 0);
    chk("total_pulses", npulse, 111);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
